// File: rtl/imem_ctrl_pkg.sv
// Shared types and store lane-plan helpers for the instruction/data memory controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP_ERR
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_e;

  function automatic logic [2:0] lane_count(size_e size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] start_lane(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'd0;
    endcase
  endfunction

  // Stores that cannot be expressed as a contiguous naturally aligned lane run.
  function automatic logic store_misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_seq.sv
// Byte-lane sequencer for stores: one memory lane per cycle from the start lane.
module store_lane_seq
  import imem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  size_e             size,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  output logic [1:0]        lane,
  output logic [DATA_W-1:0] lane_wdata,
  output logic              last
);

  logic [1:0]        lane_q;
  logic [1:0]        remain_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        start;
  logic [2:0]        count;

  assign start = start_lane(size, off);
  assign count = lane_count(size);

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q   <= '0;
      remain_q <= '0;
      wdata_q  <= '0;
    end else if (load) begin
      lane_q   <= start;
      remain_q <= 2'(count - 3'd1);
      wdata_q  <= wdata << {start, 3'b000};
    end else if (advance) begin
      lane_q <= lane_q + 2'd1;
      if (remain_q != 2'd0) remain_q <= remain_q - 2'd1;
    end
  end

  assign lane       = lane_q;
  assign lane_wdata = wdata_q;
  assign last       = (remain_q == 2'd0);

endmodule

// File: rtl/imem_access_ctrl.sv
// Single-port memory controller arbitrating fetch (IF) and load/store (LS) requesters.
// Define IMEM_RR_ARB_EN for round-robin arbitration; default is fixed LS-over-IF priority.
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_we,
  input  logic [1:0]        ls_req_size,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [1:0]        ls_req_off,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_str,
  output logic [1:0]        mem_byte_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state, state_n;
  req_e              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              grant_if, grant_ls, accept_if, accept_ls, ls_bad;
  logic [1:0]        lane;
  logic [DATA_W-1:0] lane_wdata;
  logic              lane_last;

`ifdef IMEM_RR_ARB_EN
  req_e last_grant_q;

  always_ff @(posedge clk) begin
    if (!rst_n)         last_grant_q <= REQ_IF;
    else if (accept_ls) last_grant_q <= REQ_LS;
    else if (accept_if) last_grant_q <= REQ_IF;
  end

  assign grant_ls = ls_req_valid && (!if_req_valid || last_grant_q == REQ_IF);
`else
  assign grant_ls = ls_req_valid;
`endif
  assign grant_if  = if_req_valid && !grant_ls;
  assign accept_if = if_req_valid && if_req_ready;
  assign accept_ls = ls_req_valid && ls_req_ready;
  assign ls_bad    = ls_req_we && store_misaligned(size_e'(ls_req_size), ls_req_off);

  store_lane_seq #(.DATA_W(DATA_W)) u_lane_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept_ls && ls_req_we && !ls_bad),
    .advance    (state == WRITE),
    .size       (size_e'(ls_req_size)),
    .off        (ls_req_off),
    .wdata      (ls_req_wdata),
    .lane       (lane),
    .lane_wdata (lane_wdata),
    .last       (lane_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept_ls)      state_n = !ls_req_we ? READ : (ls_bad ? RESP_ERR : WRITE);
        else if (accept_if) state_n = READ;
      end
      READ:     state_n = IDLE;
      WRITE:    if (lane_last) state_n = IDLE;
      RESP_ERR: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_str       = 1'b0;
    mem_byte_mask = 2'd0;
    case (state)
      IDLE: begin
        // Ready is masked during reset so no request is accepted while rst_n is low.
        if_req_ready = rst_n && grant_if;
        ls_req_ready = rst_n && grant_ls;
      end
      READ: mem_addr = addr_q;
      WRITE: begin
        mem_addr      = addr_q;
        mem_str       = 1'b1;
        mem_byte_mask = lane;
        mem_wdata     = lane_wdata;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Request capture and registered responses; error acks launch straight from acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q        <= REQ_IF;
      addr_q       <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_data  <= '0;
      ls_rsp_err   <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if (accept_ls) begin
        req_q  <= REQ_LS;
        addr_q <= ls_req_addr;
        if (ls_bad) begin
          ls_rsp_valid <= 1'b1;
          ls_rsp_data  <= '0;
          ls_rsp_err   <= 1'b1;
        end
      end else if (accept_if) begin
        req_q  <= REQ_IF;
        addr_q <= if_req_addr;
      end
      if (state == READ) begin
        if (req_q == REQ_IF) begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rdata;
        end else begin
          ls_rsp_valid <= 1'b1;
          ls_rsp_data  <= mem_rdata;
          ls_rsp_err   <= 1'b0;
        end
      end
      if (state == WRITE && lane_last) begin
        ls_rsp_valid <= 1'b1;
        ls_rsp_data  <= '0;
        ls_rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl: byte-level memory reference model, directed and random traffic.
module tb_imem_access_ctrl;

  localparam int ADDR_W = 12;

  logic              clk, rst_n;
  logic              if_req_valid, if_req_ready, if_rsp_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic [31:0]       if_rsp_data;
  logic              ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid, ls_rsp_err;
  logic [1:0]        ls_req_size, ls_req_off;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [31:0]       ls_req_wdata, ls_rsp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_str, busy;
  logic [1:0]        mem_byte_mask;

  imem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_size(ls_req_size), .ls_req_addr(ls_req_addr), .ls_req_off(ls_req_off),
    .ls_req_wdata(ls_req_wdata), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ls_rsp_err(ls_rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_str(mem_str),
    .mem_byte_mask(mem_byte_mask), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] wdata;
  } wr_t;

  exp_t        if_q[$];
  exp_t        ls_q[$];
  wr_t         wlog[$];
  int          grant_log[$];   // 0 = IF, 1 = LS, in acceptance order
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] w_tmp;
  exp_t        mon_if, mon_ls;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          last_ls = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory array: combinational read, one byte lane written per str edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_str) begin
      w_tmp = mem[mem_addr];
      w_tmp[8*mem_byte_mask +: 8] = mem_wdata[8*mem_byte_mask +: 8];
      mem[mem_addr] <= w_tmp;
      wlog.push_back('{mem_byte_mask, mem_wdata});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_rsp_valid) begin
        tests++;
        if (if_q.size() == 0) begin
          fails++;
          $display("FAIL if_unexpected_rsp: got data %h with nothing outstanding", if_rsp_data);
        end else begin
          mon_if = if_q.pop_front();
          check("if_data", if_rsp_data, mon_if.data);
          check("if_latency", 32'(cyc), 32'(mon_if.due));
        end
      end
      if (ls_rsp_valid) begin
        tests++;
        if (ls_q.size() == 0) begin
          fails++;
          $display("FAIL ls_unexpected_rsp: got data %h err %b with nothing outstanding",
                   ls_rsp_data, ls_rsp_err);
        end else begin
          mon_ls = ls_q.pop_front();
          check("ls_data", ls_rsp_data, mon_ls.data);
          check("ls_err", 32'(ls_rsp_err), 32'(mon_ls.err));
          check("ls_latency", 32'(cyc), 32'(mon_ls.due));
        end
      end
      if (!mem_str) check("mask_idle_zero", 32'(mem_byte_mask), 32'd0);
      if (busy) check("ready_low_busy", 32'({if_req_ready, ls_req_ready}), 32'd0);
    end
  end

  task automatic do_if(input logic [ADDR_W-1:0] addr);
    bit ok = 0;
    @(posedge clk); #1;
    if_req_valid = 1'b1;
    if_req_addr  = addr;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (if_req_ready) begin ok = 1; break; end
    end
    if (ok) begin
      if_q.push_back('{ref_mem[addr], 1'b0, cyc + 2});
      last_ls = 0;
      grant_log.push_back(0);
    end else begin
      tests++; fails++;
      $display("FAIL if_accept_timeout: addr %h never accepted", addr);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
  endtask

  // Reference model: applies a store byte by byte to ref_mem and predicts the ack.
  task automatic do_ls(input bit we, input logic [1:0] size, input logic [1:0] off,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    bit          ok = 0;
    int          nb, st;
    logic [31:0] w;
    @(posedge clk); #1;
    ls_req_valid = 1'b1;
    ls_req_we    = we;
    ls_req_size  = size;
    ls_req_off   = off;
    ls_req_addr  = addr;
    ls_req_wdata = wdata;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ls_req_ready) begin ok = 1; break; end
    end
    if (ok) begin
      last_ls = 1;
      grant_log.push_back(1);
      if (!we) begin
        ls_q.push_back('{ref_mem[addr], 1'b0, cyc + 2});
      end else if (size == 2'd3 || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0)) begin
        ls_q.push_back('{32'd0, 1'b1, cyc + 1});
      end else begin
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        st = (size == 2'd0) ? int'(off) : (size == 2'd1) ? 2 * int'(off[1]) : 0;
        w  = ref_mem[addr];
        for (int k = 0; k < nb; k++) w[8*(st+k) +: 8] = wdata[8*k +: 8];
        ref_mem[addr] = w;
        ls_q.push_back('{32'd0, 1'b0, cyc + 1 + nb});
      end
    end else begin
      tests++; fails++;
      $display("FAIL ls_accept_timeout: addr %h never accepted", addr);
    end
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_q.size() == 0 && ls_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL quiet_timeout: if_q %0d ls_q %0d busy %b", if_q.size(), ls_q.size(), busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_first;
    bit seen;
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = $urandom;
      ref_mem[a] = mem[a];
    end
    mem[12'h010]     = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_size = 2'd0; ls_req_off = 2'd0;
    ls_req_addr = '0; ls_req_wdata = '0;

    // Reset held with both requesters pending; LS load wins first, then the fetch of 0x010.
    fork
      do_ls(1'b0, 2'd2, 2'd0, 12'h004, 32'd0);
      do_if(12'h010);
      begin
        repeat (3) begin
          @(posedge clk); @(negedge clk);
          check("rst_ctrl_outs", 32'({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                                      ls_rsp_err, mem_str, busy, mem_byte_mask}), 32'd0);
          check("rst_mem_addr", 32'(mem_addr), 32'd0);
          check("rst_mem_wdata", mem_wdata, 32'd0);
          check("rst_rsp_data", if_rsp_data | ls_rsp_data, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ls_ready", 32'(ls_req_ready), 32'd1);
        check("post_rst_if_ready", 32'(if_req_ready), 32'd0);
      end
    join
    wait_quiet();

    // Word store: four lanes 0..3, full word presented on every lane.
    wlog.delete();
    do_ls(1'b1, 2'd2, 2'd0, 12'h004, 32'h11223344);
    wait_quiet();
    check("word_lane_count", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wlog.size()) begin
        check("word_lane_mask", 32'(wlog[k].mask), 32'(k));
        check("word_lane_wdata", wlog[k].wdata, 32'h11223344);
      end
    end

    // Byte store at offset 2.
    wlog.delete();
    do_ls(1'b1, 2'd0, 2'd2, 12'h005, 32'h000000AB);
    wait_quiet();
    check("byte_lane_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) begin
      check("byte_lane_mask", 32'(wlog[0].mask), 32'd2);
      check("byte_lane_data", 32'(wlog[0].wdata[23:16]), 32'hAB);
    end

    // Misaligned half store: error ack, nothing written.
    wlog.delete();
    do_ls(1'b1, 2'd1, 2'd1, 12'h006, 32'h00001234);
    wait_quiet();
    check("half_err_no_write", 32'(wlog.size()), 32'd0);

    do_ls(1'b0, 2'd2, 2'd0, 12'h005, 32'd0);
    do_if(12'h004);
    wait_quiet();

    // Simultaneous requests.
    grant_log.delete();
`ifdef IMEM_RR_ARB_EN
    exp_first = last_ls ? 0 : 1;
`else
    exp_first = 1;
`endif
    fork
      do_if(12'h007);
      do_ls(1'b0, 2'd2, 2'd0, 12'h010, 32'd0);
    join
    wait_quiet();
    check("arb_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("arb_first", 32'(grant_log[0]), 32'(exp_first));
      check("arb_second", 32'(grant_log[1]), 32'(1 - exp_first));
    end

    // Reset during lane 2 of a word store: no ack, IDLE right after.
    do_ls(1'b1, 2'd2, 2'd0, 12'h100, 32'hCAFEF00D);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_str && mem_byte_mask == 2'd2) begin seen = 1; break; end
    end
    check("mid_write_lane2_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    ls_q.delete();
    last_ls = 0;
    @(posedge clk); #1;
    check("mid_rst_idle", 32'({busy, mem_str, ls_rsp_valid}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Random concurrent traffic over a small address window.
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_if(12'($urandom_range(0, 15)));
        end
      end
      begin
        for (int n = 0; n < 80; n++) begin
          bit         we;
          logic [1:0] sz, of;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          we = 1'($urandom_range(0, 1));
          sz = we ? 2'($urandom_range(0, 3)) : 2'd2;
          of = we ? 2'($urandom_range(0, 3)) : 2'd0;
          do_ls(we, sz, of, 12'($urandom_range(0, 15)), $urandom);
        end
      end
    join
    wait_quiet();

    // Final sweep reads back every word the random phase could have touched.
    for (int a = 0; a < 16; a++) do_ls(1'b0, 2'd2, 2'd0, 12'(a), 32'd0);
    wait_quiet();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
Single-port controller for the instruction/data memory array. Arbitrates between the instruction-fetch requester (IF) and the load/store requester (LS). Sequences sub-word and word stores as one-byte-lane-per-cycle writes using the memory's 2-bit byte-lane select. Sits between the core front end, the LSU and the memory array; it is the only driver of the memory's address, data_in, str and byte_masking inputs.

Parameters:
ADDR_W, 12, word-address width; matches memory depth 2**ADDR_W
DATA_W, 32, word width; fixed at 32 (four byte lanes)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch accepted this cycle
if_req_addr  in  ADDR_W  fetch word address
if_rsp_valid  out  1  one-cycle pulse, fetch data valid
if_rsp_data  out  32  fetched word
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  LS accepted this cycle
ls_req_we  in  1  1=store, 0=load
ls_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
ls_req_addr  in  ADDR_W  word address
ls_req_off  in  2  byte offset within word
ls_req_wdata  in  32  store data, LSB-justified
ls_rsp_valid  out  1  one-cycle pulse: load data or store done
ls_rsp_data  out  32  loaded word (0 for stores)
ls_rsp_err  out  1  misaligned or illegal-size request; qualified by ls_rsp_valid
mem_addr  out  ADDR_W  to memory address
mem_wdata  out  32  to memory data_in
mem_str  out  1  to memory str
mem_byte_mask  out  2  to memory byte_masking (lane index)
mem_rdata  in  32  from memory data_out (combinational read)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0: ready, rsp_valid, rsp_data, rsp_err, mem_*, busy.
- Reset mid-write aborts the sequence; lanes already written stay written; no response issued.
- FSM states: IDLE, READ, WRITE, RESP_ERR.
- IDLE: ready is combinational and asserted only for the granted requester. Both ready signals are low in every other state.
- Arbitration: fixed priority, LS over IF. Both valid in the same cycle -> LS granted, IF waits.
- Handshake: a request is accepted on valid&ready at a posedge. Requester must hold its fields stable until accepted. The controller latches all request fields at acceptance.
- Load or fetch:
  - IDLE->READ on acceptance.
  - In READ: mem_addr = latched address, mem_str=0. mem_rdata is registered into rsp_data at the end of READ.
  - rsp_valid pulses in the following cycle, concurrent with the return to IDLE.
  - Latency: acceptance edge N -> rsp_valid high in cycle N+2.
  - Throughput: one access per 2 cycles. A new request can be accepted in the rsp_valid cycle.
- Store lane plan:
  - byte: 1 lane, start = off.
  - half: 2 lanes, start = {off[1],0}.
  - word: 4 lanes, start = 0.
- Store alignment check: half with off[0]=1, word with off!=0, or size=11 -> RESP_ERR. RESP_ERR writes nothing, pulses ls_rsp_valid with ls_rsp_err=1 for one cycle, then returns to IDLE.
- Store data alignment: mem_wdata = wdata shifted left by 8*start. Only the active lane's byte is meaningful.
- WRITE:
  - One lane per cycle: mem_str=1, mem_byte_mask = current lane, mem_addr = latched address.
  - A 2-bit lane counter increments each cycle and wraps 3->0 (unused in legal plans).
  - After the last lane: ls_rsp_valid=1 with ls_rsp_data=0, mem_str=0, return to IDLE.
  - Store durations from acceptance to ack: byte 2 cycles, half 3, word 5.
- mem_str is never asserted outside WRITE. mem_byte_mask is 0 when mem_str=0.
- An IF request arriving during an LS operation waits, unaffected.

Optional Feature:
Macro IMEM_RR_ARB_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register is cleared to IF by reset. On simultaneous requests the requester not granted last wins. The register updates on every acceptance.
- Undefined: fixed LS-over-IF priority as described above.

Decomposition:
- Package imem_ctrl_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_ILL)
  - state enum (IDLE, READ, WRITE, RESP_ERR)
  - requester enum (REQ_IF, REQ_LS)
  - lane-count function and start-lane function of (size, off)
- One sub-module: store_lane_seq. Holds the lane counter and remaining-lane count, and generates mem_byte_mask/mem_wdata shift and the last-lane flag.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valids high -> all outputs 0, no acceptance; release -> LS accepted first cycle.
- Fetch addr 0x010 with mem[0x010]=0xDEADBEEF -> if_rsp_valid one cycle, 2 cycles after acceptance, data 0xDEADBEEF.
- Word store 0x11223344 at addr 0x004 -> 4 cycles mem_str=1 with masks 0,1,2,3 and mem_wdata=0x11223344, then ls_rsp_valid with err=0.
- Byte store wdata=0xAB, off=2 -> one mem_str cycle, mask=2, mem_wdata[23:16]=0xAB.
- Half store off=1 -> no mem_str, ls_rsp_valid with err=1 one cycle after acceptance.
- Simultaneous IF and LS valid -> LS served first (or alternating under IMEM_RR_ARB_EN). IF served next, no request lost. Reset asserted during lane 2 of a word store -> no ack, IDLE next cycle.
